// File: rtl/voice_pkg.sv
// rtl/voice_pkg.sv - shared types and helpers for the voice frame mixer
// Contents:
//   state_t  : mixer sequencing states (IDLE, REQ, MIX, DONE)
//   ch_width : channel-index width, never less than one bit
package voice_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchroniser with rising-edge pulse
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   async_in   : signal from a foreign clock domain
//   level      : synchronised copy of async_in
//   rise       : one-cycle pulse on a synchronised 0->1 transition
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/voice_frame_mixer.sv
// rtl/voice_frame_mixer.sv - multi-channel frame mixer with effect crossfade
// Ports:
//   clk, reset            : system clock, asynchronous active-high reset
//   new_frame, change_en  : asynchronous frame strobe and effect-enable level
//   rec_data              : recorded samples, channel c at [c*WIDTH +: WIDTH]
//   fx_req/fx_ch/fx_sample_in, fx_ack/fx_sample_out : effect unit handshake
//   play_data, play_valid : mixed frame and its one-cycle update pulse
//   xfade_level           : crossfade position k, 0..2^XFADE_LOG2
//   overrun, fx_err       : sticky dropped-frame and effect-timeout flags
module voice_frame_mixer
    import voice_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 24,
    parameter int PROC_WIDTH = 16,
    parameter int XFADE_LOG2 = 6,
    parameter int FX_TIMEOUT = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              new_frame,
    input  logic                              change_en,
    input  logic [CHANNELS*WIDTH-1:0]         rec_data,
    output logic                              fx_req,
    output logic [ch_width(CHANNELS)-1:0]     fx_ch,
    output logic [PROC_WIDTH-1:0]             fx_sample_in,
    input  logic                              fx_ack,
    input  logic [PROC_WIDTH-1:0]             fx_sample_out,
    output logic [CHANNELS*WIDTH-1:0]         play_data,
    output logic                              play_valid,
    output logic [XFADE_LOG2:0]               xfade_level,
    output logic                              overrun,
    output logic                              fx_err
);

    localparam int CW = ch_width(CHANNELS);
    localparam int KW = XFADE_LOG2 + 1;
    localparam int N  = 1 << XFADE_LOG2;
    localparam int IW = PROC_WIDTH + XFADE_LOG2 + 2;
    localparam int TW = $clog2(FX_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

    state_t                       state, state_nxt;
    logic                         frame_edge, chg_lvl, unused_chg_rise;
    logic [KW-1:0]                k;
    logic [CW-1:0]                ch;
    logic [TW-1:0]                wait_cnt;
    logic signed [PROC_WIDTH-1:0] dry [CHANNELS];
    logic signed [PROC_WIDTH-1:0] out [CHANNELS];
    logic signed [PROC_WIDTH-1:0] wet, cur_dry, mix_val;
    logic signed [IW-1:0]         wet_ext, dry_ext, k_ext, nk_ext, mix_sum;
    logic                         k_zero, timeout;
    logic                         unused_rec;

    // Only the sample MSBs are processed.
    assign unused_rec = ^rec_data;

    sync_edge_det #(.STAGES(2)) u_frame_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (new_frame),
        .level    (),
        .rise     (frame_edge)
    );

    sync_edge_det #(.STAGES(2)) u_change_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (change_en),
        .level    (chg_lvl),
        .rise     (unused_chg_rise)
    );

    assign cur_dry = dry[ch];
    assign k_zero  = (k == '0);
    // Counter reaches FX_TIMEOUT-1 on the last permitted cycle of fx_req.
    assign timeout = (wait_cnt == TW'(FX_TIMEOUT - 1));

    // Linear crossfade; the intermediate cannot overflow, so the arithmetic
    // shift alone yields a floor-rounded result that fits in PROC_WIDTH.
    assign wet_ext = {{(IW-PROC_WIDTH){wet[PROC_WIDTH-1]}}, wet};
    assign dry_ext = {{(IW-PROC_WIDTH){cur_dry[PROC_WIDTH-1]}}, cur_dry};
    assign k_ext   = {{(IW-KW){1'b0}}, k};
    assign nk_ext  = IW'(N) - k_ext;
    assign mix_sum = wet_ext * k_ext + dry_ext * nk_ext;
    assign mix_val = PROC_WIDTH'(mix_sum >>> XFADE_LOG2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (frame_edge) state_nxt = REQ;
            REQ:  if (k_zero || fx_ack || timeout) state_nxt = MIX;
            MIX:  state_nxt = (ch == LAST_CH) ? DONE : REQ;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fx_req       = (state == REQ) && !k_zero;
        fx_ch        = ch;
        fx_sample_in = cur_dry;
        xfade_level  = k;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k          <= '0;
            ch         <= '0;
            wait_cnt   <= '0;
            wet        <= '0;
            play_data  <= '0;
            play_valid <= 1'b0;
            overrun    <= 1'b0;
            fx_err     <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                dry[c] <= '0;
                out[c] <= '0;
            end
        end else begin
            // Registered so the pulse coincides with the new play_data.
            play_valid <= (state == DONE);
            if (frame_edge && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (frame_edge) begin
                    for (int c = 0; c < CHANNELS; c++)
                        dry[c] <= rec_data[c*WIDTH+WIDTH-1 -: PROC_WIDTH];
                    if (chg_lvl && k < KW'(N))    k <= k + 1'b1;
                    else if (!chg_lvl && !k_zero) k <= k - 1'b1;
                    ch       <= '0;
                    wait_cnt <= '0;
                end
                REQ: begin
                    if (k_zero) begin
                        wet <= cur_dry;
                    end else if (fx_ack) begin
                        wet <= fx_sample_out;
                    end else if (timeout) begin
                        wet    <= cur_dry;
                        fx_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                MIX: begin
                    out[ch]  <= mix_val;
                    wait_cnt <= '0;
                    if (ch != LAST_CH) ch <= ch + 1'b1;
                end
                DONE: begin
                    for (int c = 0; c < CHANNELS; c++)
                        play_data[c*WIDTH +: WIDTH] <=
                            {out[c], {(WIDTH-PROC_WIDTH){1'b0}}};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_frame_mixer.sv
// tb/tb_voice_frame_mixer.sv - self-checking bench for voice_frame_mixer
module tb_voice_frame_mixer;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_frame, change_en;
    logic [47:0] rec_data;
    logic        fx_req;
    logic [0:0]  fx_ch;
    logic [15:0] fx_sample_in;
    logic        fx_ack;
    logic [15:0] fx_sample_out;
    logic [47:0] play_data;
    logic        play_valid;
    logic [6:0]  xfade_level;
    logic        overrun, fx_err;

    int tests = 0;
    int fails = 0;

    int          ack_delay;
    logic [15:0] fx_const [2];
    int          req_cycles = 0;
    int          pv_count   = 0;

    int          k_m;
    bit          err_m, ovr_m;
    logic [47:0] exp_play;

    voice_frame_mixer #(
        .CHANNELS(2), .WIDTH(24), .PROC_WIDTH(16), .XFADE_LOG2(6), .FX_TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .new_frame(new_frame), .change_en(change_en),
        .rec_data(rec_data), .fx_req(fx_req), .fx_ch(fx_ch),
        .fx_sample_in(fx_sample_in), .fx_ack(fx_ack), .fx_sample_out(fx_sample_out),
        .play_data(play_data), .play_valid(play_valid), .xfade_level(xfade_level),
        .overrun(overrun), .fx_err(fx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fx_req) req_cycles++;
        if (play_valid) pv_count++;
    end

    // Effect unit: answers a request after ack_delay cycles (negative = never).
    initial begin
        int d;
        fx_ack = 1'b0;
        fx_sample_out = '0;
        forever begin
            @(posedge clk); #1;
            d = ack_delay;
            if (fx_req && d >= 0) begin
                for (int i = 0; i < d && fx_req; i++) begin
                    @(posedge clk); #1;
                end
                if (fx_req) begin
                    fx_ack = 1'b1;
                    fx_sample_out = fx_const[fx_ch];
                    @(posedge clk); #1;
                    fx_ack = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: per-frame crossfade computed with floor division.
    task automatic model_frame(input logic [47:0] data, input bit chg, input int delay,
                               input logic [15:0] fx0, input logic [15:0] fx1);
        logic [15:0] d [2];
        logic [15:0] fx [2];
        logic [15:0] w;
        logic [15:0] res [2];
        int di, wi, num, q;
        if (chg && k_m < 64) k_m++;
        else if (!chg && k_m > 0) k_m--;
        d[0] = data[23:8];
        d[1] = data[47:32];
        fx[0] = fx0;
        fx[1] = fx1;
        for (int c = 0; c < 2; c++) begin
            if (k_m == 0) w = d[c];
            else if (delay >= 0 && delay < 16) w = fx[c];
            else begin
                w = d[c];
                err_m = 1'b1;
            end
            di = int'($signed(d[c]));
            wi = int'($signed(w));
            num = wi * k_m + di * (64 - k_m);
            q = num / 64;
            if (num < 0 && (num % 64) != 0) q--;
            res[c] = q[15:0];
        end
        exp_play = {res[1], 8'h00, res[0], 8'h00};
    endtask

    task automatic wait_pv(input int pv0);
        for (int i = 0; i < 400 && pv_count == pv0; i++) @(negedge clk);
    endtask

    task automatic pulse_frame();
        new_frame = 1'b1;
        repeat (4) @(negedge clk);
        new_frame = 1'b0;
    endtask

    task automatic run_frame(input logic [47:0] data, input bit chg, input int delay,
                             input logic [15:0] fx0, input logic [15:0] fx1);
        int pv0, rq0;
        rec_data = data;
        change_en = chg;
        ack_delay = delay;
        fx_const[0] = fx0;
        fx_const[1] = fx1;
        model_frame(data, chg, delay, fx0, fx1);
        pv0 = pv_count;
        rq0 = req_cycles;
        repeat (3) @(negedge clk);
        pulse_frame();
        wait_pv(pv0);
        repeat (3) @(negedge clk);
        check("play_valid_once", 64'(pv_count - pv0), 64'd1);
        check("play_data", 64'(play_data), 64'(exp_play));
        check("xfade_level", 64'(xfade_level), 64'(k_m));
        check("fx_err", 64'(fx_err), 64'(err_m));
        check("overrun", 64'(overrun), 64'(ovr_m));
        if (k_m == 0)       check("req_cycles_bypass", 64'(req_cycles - rq0), 64'd0);
        else if (delay < 0) check("req_cycles_timeout", 64'(req_cycles - rq0), 64'd32);
        else                check("req_cycles_ack", 64'(req_cycles - rq0), 64'(2 * (delay + 1)));
    endtask

    initial begin
        logic [47:0] r;
        int pv0, rq0;
        reset = 1'b1;
        new_frame = 1'b0;
        change_en = 1'b0;
        rec_data = '0;
        ack_delay = -1;
        fx_const[0] = '0;
        fx_const[1] = '0;
        k_m = 0;
        err_m = 1'b0;
        ovr_m = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_play_data", 64'(play_data), 64'd0);
        check("rst_play_valid", 64'(play_valid), 64'd0);
        check("rst_xfade", 64'(xfade_level), 64'd0);
        check("rst_fx_req", 64'(fx_req), 64'd0);
        check("rst_flags", 64'({overrun, fx_err}), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Bypass at k=0.
        run_frame(48'hFEDCBA_123456, 1'b0, 2, 16'h7777, 16'h7777);
        check("bypass_data", 64'(play_data), 64'h0000_FEDC00_123400);

        // Ramp up to full effect and beyond.
        for (int f = 1; f <= 66; f++) begin
            run_frame(48'h100000_100000, 1'b1, 2, 16'h3000, 16'h3000);
            if (f == 32) check("half_mix", 64'(play_data), 64'h0000_200000_200000);
            if (f >= 64) check("full_wet", 64'(play_data), 64'h0000_300000_300000);
        end

        // Ramp down with random samples, effect values and ack latency.
        for (int f = 1; f <= 66; f++) begin
            r = {$urandom(), $urandom()};
            run_frame(r, 1'b0, int'($urandom_range(0, 8)),
                      16'($urandom()), 16'($urandom()));
        end

        // Effect never answers: both channels time out.
        r = {$urandom(), $urandom()};
        run_frame(r, 1'b1, -1, 16'h1111, 16'h2222);

        // Second frame arrives while the first is still in flight.
        r = {$urandom(), $urandom()};
        rec_data = r;
        change_en = 1'b1;
        ack_delay = 10;
        fx_const[0] = 16'hA5A5;
        fx_const[1] = 16'h5A5A;
        model_frame(r, 1'b1, 10, 16'hA5A5, 16'h5A5A);
        ovr_m = 1'b1;
        pv0 = pv_count;
        repeat (3) @(negedge clk);
        pulse_frame();
        repeat (16) @(negedge clk);
        pulse_frame();
        wait_pv(pv0);
        repeat (60) @(negedge clk);
        check("ovr_pv_once", 64'(pv_count - pv0), 64'd1);
        check("ovr_flag", 64'(overrun), 64'd1);
        check("ovr_k_once", 64'(xfade_level), 64'(k_m));
        check("ovr_data", 64'(play_data), 64'(exp_play));

        // Reset while a request is outstanding.
        ack_delay = -1;
        rec_data = {$urandom(), $urandom()};
        pv0 = pv_count;
        pulse_frame();
        repeat (4) @(negedge clk);
        check("req_before_reset", 64'(fx_req), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_fx_req", 64'(fx_req), 64'd0);
        check("rst_mid_pv", 64'(play_valid), 64'd0);
        check("rst_mid_k", 64'(xfade_level), 64'd0);
        check("rst_mid_flags", 64'({overrun, fx_err}), 64'd0);
        k_m = 0;
        err_m = 1'b0;
        ovr_m = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_no_pv", 64'(pv_count - pv0), 64'd0);
        r = {$urandom(), $urandom()};
        run_frame(r, 1'b1, 2, 16'($urandom()), 16'($urandom()));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
